// File: rtl/shadow_wr_sched_pkg.sv
// Shared types for the shadowed-register write scheduler: FSM encoding,
// retry counter width and the index-width helper.
package shadow_wr_sched_pkg;

  localparam int RetryW = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_WR1    = 3'd2,
    ST_WR2    = 3'd3,
    ST_CHECK  = 3'd4,
    ST_RESP   = 3'd5,
    ST_LOCKED = 3'd6
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shadow_wr_sched_if.sv
// Requester and shadowed-register signals of the write scheduler.
// slave = scheduler side, master = requesters plus register side.
interface shadow_wr_sched_if #(
  parameter int NumReq = 4,
  parameter int DW     = 32
);
  logic [NumReq-1:0]    req_i;
  logic [NumReq*DW-1:0] wdata_i;
  logic [NumReq-1:0]    done_o;
  logic [NumReq-1:0]    err_o;
  logic                 busy_o;
  logic                 locked_o;
  logic                 we_o;
  logic [DW-1:0]        wd_o;
  logic                 re_o;
  logic                 phase_i;
  logic                 err_update_i;
  logic                 err_storage_i;

  modport slave (
    input  req_i, wdata_i, phase_i, err_update_i, err_storage_i,
    output done_o, err_o, busy_o, locked_o, we_o, wd_o, re_o
  );

  modport master (
    output req_i, wdata_i, phase_i, err_update_i, err_storage_i,
    input  done_o, err_o, busy_o, locked_o, we_o, wd_o, re_o
  );
endinterface

// File: rtl/shadow_wr_sched_rr_arb.sv
// Combinational round-robin pick: lowest set request at or above ptr,
// wrapping to the lowest set request overall.
module shadow_wr_rr_arb
  import shadow_wr_sched_pkg::*;
#(
  parameter  int NumReq = 4,
  localparam int IdxW   = idx_w(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [IdxW-1:0]   idx,
  output logic              vld
);

  logic [NumReq-1:0] hi;

  always_comb begin
    hi  = '0;
    idx = '0;
    vld = |req;
    for (int j = 0; j < NumReq; j++) hi[j] = req[j] && (j >= int'(ptr));
    for (int j = NumReq - 1; j >= 0; j--) if (req[j]) idx = IdxW'(j);
    // an upper-half hit overrides the wrapped pick
    for (int j = NumReq - 1; j >= 0; j--) if (hi[j]) idx = IdxW'(j);
  end

endmodule

// File: rtl/shadow_wr_sched.sv
// Arbitrates requesters onto one shadowed register and runs the staged/commit
// write pair with phase checking, bounded commit retry and storage-error lockout.
module shadow_wr_sched
  import shadow_wr_sched_pkg::*;
#(
  parameter int NumReq   = 4,
  parameter int DW       = 32,
  parameter int MaxRetry = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  shadow_wr_sched_if.slave bus
);

  localparam int IdxW = idx_w(NumReq);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_q, rr_d, idx_q, idx_d, lk_idx_q, lk_idx_d, pick, rr_nxt;
  logic              pick_vld, lk_vld_q, lk_vld_d, err_q, err_d, locked_q;
  logic              we, re, in_flight;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [DW-1:0]     wd_q, wd_d;
  logic [NumReq-1:0] arb_req, sel_oh, lk_oh;

  for (genvar i = 0; i < NumReq; i++) begin : g_oh
    assign sel_oh[i] = (idx_q == IdxW'(i));
    assign lk_oh[i]  = lk_vld_q && (lk_idx_q == IdxW'(i));
  end

  // the requester being answered this cycle still holds req; keep it out of the pick
  assign arb_req   = bus.req_i & ~lk_oh;
  assign rr_nxt    = (pick == IdxW'(NumReq - 1)) ? '0 : pick + 1'b1;
  assign in_flight = state_q inside {ST_CLR, ST_WR1, ST_WR2, ST_CHECK};

  shadow_wr_rr_arb #(.NumReq(NumReq)) u_arb (
    .req (arb_req),
    .ptr (rr_q),
    .idx (pick),
    .vld (pick_vld)
  );

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    idx_d    = idx_q;
    wd_d     = wd_q;
    retry_d  = retry_q;
    err_d    = err_q;
    lk_vld_d = 1'b0;
    lk_idx_d = lk_idx_q;
    we       = 1'b0;
    re       = 1'b0;
    unique case (state_q)
      ST_IDLE: if (pick_vld) begin
        idx_d   = pick;
        wd_d    = bus.wdata_i[int'(pick)*DW +: DW];
        rr_d    = rr_nxt;
        state_d = bus.phase_i ? ST_CLR : ST_WR1;
      end
      ST_CLR: begin
        re      = 1'b1;
        state_d = ST_WR1;
      end
      ST_WR1: begin
        we      = 1'b1;
        state_d = ST_WR2;
      end
      ST_WR2: begin
        we = 1'b1;
        // a failed commit toggles phase back to 0, so retry restarts at WR1
        if (bus.err_update_i) begin
          if (retry_q < RetryW'(MaxRetry)) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_WR1;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bus.phase_i) begin
          err_d = 1'b1;
          re    = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        retry_d = '0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      ST_LOCKED: if (pick_vld) begin
        lk_vld_d = 1'b1;
        lk_idx_d = pick;
        rr_d     = rr_nxt;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.err_storage_i) begin
      state_d = ST_LOCKED;
      we      = 1'b0;
      re      = 1'b0;
      retry_d = '0;
      err_d   = 1'b0;
      if (in_flight) begin
        lk_vld_d = 1'b1;
        lk_idx_d = idx_q;
      end
      if (state_q == ST_IDLE) begin
        rr_d  = rr_q;
        idx_d = idx_q;
        wd_d  = wd_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      idx_q    <= '0;
      wd_q     <= '0;
      retry_q  <= '0;
      err_q    <= 1'b0;
      lk_vld_q <= 1'b0;
      lk_idx_q <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      idx_q    <= idx_d;
      wd_q     <= wd_d;
      retry_q  <= retry_d;
      err_q    <= err_d;
      lk_vld_q <= lk_vld_d;
      lk_idx_q <= lk_idx_d;
      locked_q <= locked_q | bus.err_storage_i;
    end
  end

  assign bus.we_o     = we;
  assign bus.re_o     = re;
  assign bus.wd_o     = wd_q;
  assign bus.busy_o   = (state_q != ST_IDLE) && (state_q != ST_LOCKED);
  assign bus.locked_o = locked_q;
  assign bus.done_o   = (state_q == ST_RESP && !err_q) ? sel_oh : '0;
  assign bus.err_o    = (state_q == ST_RESP &&  err_q) ? sel_oh : lk_oh;

endmodule

// File: tb/tb_shadow_wr_sched.sv
// Directed bench for shadow_wr_sched with a behavioural shadowed-register
// model and a response scoreboard.
module tb_shadow_wr_sched;

  typedef struct {
    logic [3:0]  done;
    logic [3:0]  err;
    logic [31:0] commit;
    bit          chk_commit;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shadow_wr_sched_if #(.NumReq(4), .DW(32)) bus ();

  shadow_wr_sched #(.NumReq(4), .DW(32), .MaxRetry(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // shadowed register model: write at phase 0 stages, write at phase 1 commits
  logic        m_ph, set_phase;
  logic [31:0] m_staged, m_commit;
  int          m_commit_n;
  int          upd_mode;  // 0 none, 1 first commit fails, 2 every commit fails

  assign bus.phase_i      = m_ph;
  assign bus.err_update_i = bus.we_o && m_ph && (upd_mode == 2 || (upd_mode == 1 && m_commit_n == 0));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= 1'b0; m_staged <= '0; m_commit <= '0; m_commit_n <= 0;
    end else if (set_phase) begin
      m_ph <= 1'b1;
    end else if (bus.re_o) begin
      m_ph <= 1'b0;
    end else if (bus.we_o) begin
      if (!m_ph) begin
        m_staged <= bus.wd_o;
        m_ph     <= 1'b1;
      end else begin
        m_ph       <= 1'b0;
        m_commit_n <= m_commit_n + 1;
        if (!bus.err_update_i) m_commit <= bus.wd_o;
      end
    end
  end

  exp_t        sbq[$];
  int          we_rel[$], re_rel[$], rsp_rel[$];
  logic [31:0] we_wd[$];
  int          neval = 0, nfail = 0, cyc_n = 0, t0 = 0, multi = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    neval++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    if (bus.we_o) begin we_rel.push_back(cyc_n - t0); we_wd.push_back(bus.wd_o); end
    if (bus.re_o) re_rel.push_back(cyc_n - t0);
    if ($countones(bus.done_o | bus.err_o) > 1) multi++;
    if ((bus.done_o | bus.err_o) != 4'b0) begin
      rsp_rel.push_back(cyc_n - t0);
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", {24'h0, bus.done_o, bus.err_o}, 32'h0);
      end else begin
        exp_t e = sbq.pop_front();
        chk("done_o", 32'(bus.done_o), 32'(e.done));
        chk("err_o", 32'(bus.err_o), 32'(e.err));
        if (e.chk_commit) chk("commit", m_commit, e.commit);
      end
      bus.req_i = bus.req_i & ~(bus.done_o | bus.err_o);
    end
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (sbq.size() != 0 && n < max) begin cyc(); n++; end
    chk("rsp_timeout", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic clr_logs();
    we_rel.delete(); re_rel.delete(); rsp_rel.delete(); we_wd.delete();
    t0 = cyc_n;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req_i = '0; bus.err_storage_i = 1'b0; set_phase = 1'b0; upd_mode = 0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1; bus.req_i = '0; bus.wdata_i = '0; bus.err_storage_i = 1'b0;
    set_phase = 1'b0; upd_mode = 0;
    repeat (2) cyc();
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_locked", 32'(bus.locked_o), 32'd0);
    chk("rst_we", 32'(bus.we_o), 32'd0);
    chk("rst_re", 32'(bus.re_o), 32'd0);
    chk("rst_rsp", 32'({bus.done_o, bus.err_o}), 32'd0);
    chk("rst_wd", bus.wd_o, 32'd0);
    rst = 1'b0;
    cyc();

    // single request, nominal latency
    clr_logs();
    bus.wdata_i[0 +: 32] = 32'hA5A5_0001; bus.req_i = 4'b0001;
    sbq.push_back('{4'b0001, 4'b0000, 32'hA5A5_0001, 1'b1});
    wait_done(20);
    chk("t1_we_cnt", 32'(we_rel.size()), 32'd2);
    if (we_rel.size() == 2) begin
      chk("t1_we_c1", 32'(we_rel[0]), 32'd1);
      chk("t1_we_c2", 32'(we_rel[1]), 32'd2);
      chk("t1_wd1", we_wd[0], 32'hA5A5_0001);
      chk("t1_wd2", we_wd[1], 32'hA5A5_0001);
    end
    if (rsp_rel.size() > 0) chk("t1_done_cyc", 32'(rsp_rel[0]), 32'd4);

    // contention from rr pointer 0
    do_reset();
    clr_logs();
    bus.wdata_i[32 +: 32] = 32'h1111_0002; bus.wdata_i[96 +: 32] = 32'h3333_0008;
    bus.req_i = 4'b1010;
    sbq.push_back('{4'b0010, 4'b0000, 32'h1111_0002, 1'b1});
    sbq.push_back('{4'b1000, 4'b0000, 32'h3333_0008, 1'b1});
    wait_done(30);
    chk("t2_rsp_cnt", 32'(rsp_rel.size()), 32'd2);
    if (rsp_rel.size() == 2) begin
      chk("t2_first_cyc", 32'(rsp_rel[0]), 32'd4);
      chk("t2_second_cyc", 32'(rsp_rel[1]), 32'd9);
    end
    chk("t2_we_cnt", 32'(we_rel.size()), 32'd4);

    // stale phase forces a clear before the writes
    do_reset();
    set_phase = 1'b1;
    cyc();
    set_phase = 1'b0;
    clr_logs();
    bus.wdata_i[0 +: 32] = 32'h5EA1_0003; bus.req_i = 4'b0001;
    sbq.push_back('{4'b0001, 4'b0000, 32'h5EA1_0003, 1'b1});
    wait_done(20);
    chk("t3_re_cnt", 32'(re_rel.size()), 32'd1);
    if (re_rel.size() == 1) chk("t3_re_cyc", 32'(re_rel[0]), 32'd1);
    chk("t3_we_cnt", 32'(we_rel.size()), 32'd2);
    if (we_rel.size() == 2) begin
      chk("t3_we_c1", 32'(we_rel[0]), 32'd2);
      chk("t3_we_c2", 32'(we_rel[1]), 32'd3);
    end
    if (rsp_rel.size() > 0) chk("t3_done_cyc", 32'(rsp_rel[0]), 32'd5);

    // one failed commit, recovered by the retry
    do_reset();
    upd_mode = 1;
    clr_logs();
    bus.wdata_i[32 +: 32] = 32'hC0DE_0004; bus.req_i = 4'b0010;
    sbq.push_back('{4'b0010, 4'b0000, 32'hC0DE_0004, 1'b1});
    wait_done(20);
    chk("t4_we_cnt", 32'(we_rel.size()), 32'd4);
    if (rsp_rel.size() > 0) chk("t4_done_cyc", 32'(rsp_rel[0]), 32'd6);

    // persistent commit failure exhausts the retry
    do_reset();
    upd_mode = 2;
    clr_logs();
    bus.wdata_i[64 +: 32] = 32'hDEAD_0005; bus.req_i = 4'b0100;
    sbq.push_back('{4'b0000, 4'b0100, 32'h0, 1'b0});
    wait_done(20);
    chk("t5_we_cnt", 32'(we_rel.size()), 32'd4);
    if (rsp_rel.size() > 0) chk("t5_err_cyc", 32'(rsp_rel[0]), 32'd5);
    cyc();
    chk("t5_busy_after", 32'(bus.busy_o), 32'd0);
    chk("t5_no_commit", m_commit, 32'd0);

    // storage error during the staged write
    do_reset();
    clr_logs();
    bus.wdata_i[0 +: 32] = 32'hBAD0_0006; bus.req_i = 4'b0001;
    sbq.push_back('{4'b0000, 4'b0001, 32'h0, 1'b0});
    cyc();
    bus.err_storage_i = 1'b1;
    cyc();
    bus.err_storage_i = 1'b0;
    wait_done(5);
    chk("t6_we_cnt", 32'(we_rel.size()), 32'd1);
    if (rsp_rel.size() > 0) chk("t6_err_cyc", 32'(rsp_rel[0]), 32'd2);
    chk("t6_locked", 32'(bus.locked_o), 32'd1);
    chk("t6_busy", 32'(bus.busy_o), 32'd0);
    repeat (3) cyc();
    clr_logs();
    bus.wdata_i[64 +: 32] = 32'h0000_0007; bus.req_i = 4'b0100;
    sbq.push_back('{4'b0000, 4'b0100, 32'h0, 1'b0});
    wait_done(5);
    if (rsp_rel.size() > 0) chk("t6_lk_err_cyc", 32'(rsp_rel[0]), 32'd1);
    chk("t6_lk_no_we", 32'(we_rel.size()), 32'd0);
    chk("t6_still_locked", 32'(bus.locked_o), 32'd1);
    rst = 1'b1;
    cyc();
    chk("t6_rst_unlock", 32'(bus.locked_o), 32'd0);
    rst = 1'b0;
    cyc();

    chk("rsp_onehot", 32'(multi), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", neval, nfail);
    $finish;
  end

endmodule
